// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle integer ALU for the execute stage.
//            - Base RV32I operations (MD=0) are returned registered, one cycle
//              after START is accepted.
//            - RV32M operations (MD=1) run on iterative radix-2 units:
//              shift-add multiply and restoring divide. Each takes WIDTH
//              iterations followed by one sign-fix cycle.
//            The control unit stalls the pipeline while BUSY is high.
// Ports    : CLK        clock, rising edge
//            RST_N      asynchronous active-low reset
//            START      operation request, sampled only in IDLE
//            MD         0 = base op (CONTROL[3:0]), 1 = M op (CONTROL[2:0])
//            CONTROL    operation code, captured with START
//            X, Y       operands (rs1, rs2/imm), captured with START
//            FLUSH      synchronous abort back to IDLE, no DONE
//            BUSY       high while an M operation is in flight
//            DONE       one-cycle pulse, RESULTADO valid from this cycle
//            RESULTADO  result, held until the next DONE
//            ZERO       RESULTADO == 0, registered with RESULTADO
// Revision : 1.0 - initial multi-cycle release
// ============================================================================
module alu_mc #(
    parameter int WIDTH     = 32,
    parameter int DIV0_FAST = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             MD,
    input  logic [3:0]       CONTROL,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULTADO,
    output logic             ZERO
);

    localparam int c_shw = $clog2(WIDTH);
    localparam logic [c_shw-1:0] c_cnt_last = c_shw'(WIDTH - 1);
    localparam logic [c_shw-1:0] c_cnt_one  = c_shw'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_shw-1:0]     r_cnt;
    logic [2:0]           r_op;
    // Multiplier: r_a = multiplicand magnitude, r_acc = {partial hi, multiplier}.
    // Divider:    r_a = divisor magnitude,      r_acc = {remainder, dividend/quotient}.
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;   // product sign or quotient sign
    logic                 r_rneg;  // remainder sign (dividend sign)
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_done;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_base;
    logic [c_shw-1:0]     w_shamt;
    logic                 w_slt;
    logic                 w_sltu;
    logic                 w_eq;

    logic                 w_xs;
    logic                 w_ys;
    logic                 w_ydz;
    logic [WIDTH-1:0]     w_ax;
    logic [WIDTH-1:0]     w_ay;

    logic [WIDTH:0]       w_madd;
    logic [WIDTH:0]       w_dshift;
    logic [WIDTH:0]       w_trial;

    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix;

    // A START presented while DONE is high belongs to the cycle the block is
    // leaving; it is dropped and must be re-presented.
    assign w_accept = START && (r_state == S_IDLE) && !r_done && !FLUSH;

    // ------------------------------------------------------------------------
    // Base (single-cycle) operations
    // ------------------------------------------------------------------------
    assign w_shamt = Y[c_shw-1:0];
    assign w_slt   = $signed(X) < $signed(Y);
    assign w_sltu  = X < Y;
    assign w_eq    = X == Y;

    always_comb begin
        w_base = '0;
        case (CONTROL)
            4'b0000: w_base = X + Y;
            4'b0111: w_base = X - Y;
            4'b1100: w_base = Y;
            4'b0010: w_base = X & Y;
            4'b0001: w_base = X | Y;
            4'b1001: w_base = X ^ Y;
            4'b0100: w_base = {{(WIDTH-1){1'b0}}, w_slt};
            4'b1101: w_base = {{(WIDTH-1){1'b0}}, w_sltu};
            4'b1000: w_base = X << w_shamt;
            4'b1010: w_base = X >> w_shamt;
            4'b1110: w_base = $unsigned($signed(X) >>> w_shamt);
            4'b1111: w_base = {{(WIDTH-1){1'b0}}, w_eq};
            4'b0011: w_base = {{(WIDTH-1){1'b0}}, !w_eq};
            4'b1011: w_base = {{(WIDTH-1){1'b0}}, !w_slt};
            default: w_base = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand conditioning at accept: both units work on magnitudes and the
    // sign is reapplied in FIX.
    // X is signed for MULH, MULHSU, DIV, REM; Y for MULH, DIV, REM.
    // ------------------------------------------------------------------------
    assign w_xs  = X[WIDTH-1] && ((CONTROL[2:0] == 3'b001) || (CONTROL[2:0] == 3'b010) ||
                                  (CONTROL[2:0] == 3'b100) || (CONTROL[2:0] == 3'b110));
    assign w_ys  = Y[WIDTH-1] && ((CONTROL[2:0] == 3'b001) || (CONTROL[2:0] == 3'b100) ||
                                  (CONTROL[2:0] == 3'b110));
    assign w_ydz = (Y == '0);
    assign w_ax  = w_xs ? -X : X;
    assign w_ay  = w_ys ? -Y : Y;

    // ------------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------------
    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the whole product right, consuming one multiplier bit.
    assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and
    // try subtracting the divisor. The remainder is always below the divisor,
    // so WIDTH+1 bits hold the trial difference and its sign.
    assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial  = w_dshift - {1'b0, r_a};

    // ------------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------------
    assign w_prod = r_neg  ? -r_acc                   : r_acc;
    assign w_quo  = r_neg  ? -r_acc[WIDTH-1:0]        : r_acc[WIDTH-1:0];
    assign w_rem  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH]  : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix = '0;
        case (r_op)
            3'b000:                 w_fix = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_fix = w_quo;
            default:                w_fix = w_rem;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && MD) begin
                        if (!CONTROL[2]) begin
                            w_state_nxt = S_MUL;
                        end else if (w_ydz && (DIV0_FAST != 0)) begin
                            w_state_nxt = S_FIX;
                        end else begin
                            w_state_nxt = S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = S_FIX;
                    end
                end
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!FLUSH) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept && !MD) begin
                            r_result <= w_base;
                            r_zero   <= (w_base == '0);
                            r_done   <= 1'b1;
                        end else if (w_accept) begin
                            r_op   <= CONTROL[2:0];
                            r_cnt  <= '0;
                            r_rneg <= w_xs;
                            if (!CONTROL[2]) begin
                                r_a   <= w_ax;
                                r_acc <= {{WIDTH{1'b0}}, w_ay};
                                r_neg <= w_xs ^ w_ys;
                            end else begin
                                r_a   <= w_ay;
                                r_neg <= (w_xs ^ w_ys) && !w_ydz;
                                // Fast divide-by-zero preloads exactly what the
                                // full iteration would leave behind.
                                if (w_ydz && (DIV0_FAST != 0)) begin
                                    r_acc <= {w_ax, {WIDTH{1'b1}}};
                                end else begin
                                    r_acc <= {{WIDTH{1'b0}}, w_ax};
                                end
                            end
                        end
                    end
                    S_MUL: begin
                        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                    S_DIV: begin
                        if (!w_trial[WIDTH]) begin
                            r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                    S_FIX: begin
                        r_result <= w_fix;
                        r_zero   <= (w_fix == '0);
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = r_done;
    assign RESULTADO = r_result;
    assign ZERO      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=32). Two instances share
//            stimulus: one with fast divide-by-zero, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        MD;
    logic [3:0]  CONTROL;
    logic [31:0] X;
    logic [31:0] Y;
    logic        FLUSH;

    logic        busy_f, done_f, zero_f;
    logic [31:0] res_f;
    logic        busy_s, done_s, zero_s;
    logic [31:0] res_s;

    int n_cmp = 0;
    int n_bad = 0;

    alu_mc #(.WIDTH(32), .DIV0_FAST(1)) u_fast (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MD(MD), .CONTROL(CONTROL),
        .X(X), .Y(Y), .FLUSH(FLUSH),
        .BUSY(busy_f), .DONE(done_f), .RESULTADO(res_f), .ZERO(zero_f)
    );

    alu_mc #(.WIDTH(32), .DIV0_FAST(0)) u_slow (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MD(MD), .CONTROL(CONTROL),
        .X(X), .Y(Y), .FLUSH(FLUSH),
        .BUSY(busy_s), .DONE(done_s), .RESULTADO(res_s), .ZERO(zero_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        md;
        logic [3:0]  ctl;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat_f;
        int          lat_s;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic md, input logic [3:0] ctl,
                                input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] e, input int lf, input int ls,
                                input string nm);
        vec_t v;
        v.md = md; v.ctl = ctl; v.x = x; v.y = y; v.exp = e;
        v.lat_f = lf; v.lat_s = ls; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after accept, and wait for
    // DONE on both instances. Latency counts rising edges from the cycle
    // START is presented.
    task automatic do_op(input vec_t v);
        int got_f, got_s, nbusy;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; MD = v.md; CONTROL = v.ctl; X = v.x; Y = v.y;
        got_f = -1; got_s = -1; nbusy = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge CLK);
            #1;
            if (c == 1) begin
                START = 1'b0; X = ~v.x; Y = v.y ^ 32'h5A5A_5A5A;
                CONTROL = ~v.ctl; MD = ~v.md;
            end
            if (busy_f) nbusy++;
            if (done_f && got_f < 0) begin
                got_f = c;
                chk({v.name, " result"}, res_f, v.exp);
                chk({v.name, " zero"}, {31'b0, zero_f}, {31'b0, (v.exp == 32'h0)});
            end
            if (done_s && got_s < 0) begin
                got_s = c;
                chk({v.name, " result(slow)"}, res_s, v.exp);
            end
            if (got_f >= 0 && got_s >= 0) break;
        end
        chk({v.name, " latency"}, 32'(got_f), 32'(v.lat_f));
        chk({v.name, " latency(slow)"}, 32'(got_s), 32'(v.lat_s));
        chk({v.name, " busy cycles"}, 32'(nbusy), 32'(v.lat_f - 1));
    endtask

    initial begin
        int got, ndone;
        vec_t v;

        RST_N = 1'b0; START = 1'b0; MD = 1'b0; CONTROL = 4'h0;
        X = 32'h0; Y = 32'h0; FLUSH = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy", {31'b0, busy_f}, 32'h0);
        chk("reset done", {31'b0, done_f}, 32'h0);
        chk("reset result", res_f, 32'h0);
        chk("reset zero", {31'b0, zero_f}, 32'h1);
        @(negedge CLK);
        RST_N = 1'b1;

        // ---------------- vector table ----------------
        add(0, 4'b0111, 32'd5,          32'd7,          32'hFFFF_FFFE, 1, 1, "SUB 5-7");
        add(0, 4'b1110, 32'h8000_0000,  32'd4,          32'hF800_0000, 1, 1, "SRA");
        add(0, 4'b0111, 32'd9,          32'd9,          32'h0,         1, 1, "SUB 9-9");
        add(0, 4'b1010, 32'h8000_0000,  32'd4,          32'h0800_0000, 1, 1, "SRL");
        add(0, 4'b1000, 32'd1,          32'h25,         32'h20,        1, 1, "SLL low bits");
        add(0, 4'b0100, 32'hFFFF_FFFF,  32'd1,          32'h1,         1, 1, "SLT");
        add(0, 4'b1101, 32'hFFFF_FFFF,  32'd1,          32'h0,         1, 1, "SLTU");
        add(0, 4'b1011, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  32'h1,         1, 1, "GE equal");
        add(0, 4'b1111, 32'd5,          32'd6,          32'h0,         1, 1, "EQ");
        add(0, 4'b0011, 32'd5,          32'd6,          32'h1,         1, 1, "NE");
        add(0, 4'b1001, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1, 1, "XOR");
        add(0, 4'b1100, 32'd5,          32'h1234_5678,  32'h1234_5678, 1, 1, "PASSY");
        add(0, 4'b0101, 32'd5,          32'd5,          32'h0,         1, 1, "undefined");
        add(1, 4'b0001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 34, 34, "MULH");
        add(1, 4'b0011, 32'hFFFF_FFFF,  32'd2,          32'h1,         34, 34, "MULHU");
        add(1, 4'b0000, 32'h0001_0000,  32'h0001_0000,  32'h0,         34, 34, "MUL 2^32");
        add(1, 4'b0010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 34, "MULHSU");
        add(1, 4'b1000, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB, 34, 34, "MUL ctl3 set");
        add(1, 4'b0100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34, 34, "DIV -7/2");
        add(1, 4'b0110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34, 34, "REM -7/2");
        add(1, 4'b0100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 34, 34, "DIV ovf");
        add(1, 4'b0110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         34, 34, "REM ovf");
        add(1, 4'b0101, 32'd123,        32'd0,          32'hFFFF_FFFF, 2, 34,  "DIVU /0");
        add(1, 4'b0111, 32'd123,        32'd0,          32'd123,       2, 34,  "REMU /0");
        add(1, 4'b0110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, 2, 34,  "REM -5/0");
        add(1, 4'b0101, 32'd100,        32'd7,          32'd14,        34, 34, "DIVU 100/7");
        add(1, 4'b0111, 32'd100,        32'd7,          32'd2,         34, 34, "REMU 100/7");

        foreach (vecs[i]) do_op(vecs[i]);

        // ---------------- START while BUSY is ignored ----------------
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; MD = 1'b1; CONTROL = 4'b0100; X = 32'd100; Y = 32'd7;
        got = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge CLK);
            #1;
            START = (c == 9);
            if (c == 9) begin
                CONTROL = 4'b0101; X = 32'd1000; Y = 32'd10;
            end
            if (done_f && got < 0) begin
                got = c;
                chk("ignored START result", res_f, 32'd14);
                chk("ignored START result(slow)", res_s, 32'd14);
            end
            if (got >= 0) break;
        end
        chk("ignored START latency", 32'(got), 32'd34);
        @(posedge CLK);
        #1;
        chk("ignored START idle after", {31'b0, busy_f}, 32'h0);

        // ---------------- FLUSH mid-divide ----------------
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; MD = 1'b1; CONTROL = 4'b0100; X = 32'd50; Y = 32'd3;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        chk("flush busy before", {31'b0, busy_f}, 32'h1);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        chk("flush busy", {31'b0, busy_f}, 32'h0);
        chk("flush busy(slow)", {31'b0, busy_s}, 32'h0);
        ndone = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done_f || done_s) ndone++;
        end
        chk("flush no done", 32'(ndone), 32'h0);
        chk("flush result held", res_f, 32'd14);
        v.md = 1'b1; v.ctl = 4'b0101; v.x = 32'd50; v.y = 32'd3; v.exp = 32'd16;
        v.lat_f = 34; v.lat_s = 34; v.name = "DIVU after flush";
        do_op(v);

        // ---------------- reset mid-multiply ----------------
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; MD = 1'b1; CONTROL = 4'b0011; X = 32'hFFFF_FFFF; Y = 32'd2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (11) @(posedge CLK);
        #1;
        chk("pre-reset busy", {31'b0, busy_f}, 32'h1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async reset busy", {31'b0, busy_f}, 32'h0);
        chk("async reset result", res_f, 32'h0);
        chk("async reset zero", {31'b0, zero_f}, 32'h1);
        chk("async reset result(slow)", res_s, 32'h0);
        ndone = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (done_f || done_s) ndone++;
        end
        chk("reset no done", 32'(ndone), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        v.md = 1'b0; v.ctl = 4'b0000; v.x = 32'd2; v.y = 32'd3; v.exp = 32'd5;
        v.lat_f = 1; v.lat_s = 1; v.name = "ADD after reset";
        do_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
